// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between writeback units.
// It also keeps a per-register pending scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int unsigned DATAW    = 32,
    parameter int unsigned ADDRW    = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_REQ  = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ADDRW-1:0] req_addr,
    input  logic [NUM_REQ*DATAW-1:0] req_data,
    input  logic                     issue_valid,
    input  logic                     issue_rd_en,
    input  logic [ADDRW-1:0]         issue_rd,
    input  logic [ADDRW-1:0]         issue_rs1,
    input  logic [ADDRW-1:0]         issue_rs2,
    output logic                     stall,
    output logic                     rf_write_enable,
    output logic [ADDRW-1:0]         rf_addr_rd,
    output logic [DATAW-1:0]         rf_data_rd
);

    localparam int unsigned PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTRW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                we_q, we_d;
    logic [ADDRW-1:0]    addr_q, addr_d;
    logic [DATAW-1:0]    data_q, data_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [PTRW-1:0]     gnt_idx;
    logic [PTRW-1:0]     cand;
    logic                found;
    logic                hs;
    logic                issue_accept;
    logic [ADDRW-1:0]    sel_addr;
    logic [DATAW-1:0]    sel_data;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = PTRW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // A grant during reset must not count as a handshake
    assign req_ready = reset_n ? gnt : '0;
    assign hs        = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDRW +: ADDRW];
                sel_data = req_data[i*DATAW +: DATAW];
            end
        end
    end

    assign stall = issue_valid && (pending_q[issue_rs1] || pending_q[issue_rs2] ||
                                   (issue_rd_en && pending_q[issue_rd]));
    assign issue_accept = issue_valid && !stall && issue_rd_en && (issue_rd != '0);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (hs) begin
            rr_ptr_d = (gnt_idx == PTRW'(NUM_REQ - 1)) ? '0 : gnt_idx + PTRW'(1);
            we_d     = (sel_addr != '0);
            addr_d   = sel_addr;
            data_d   = sel_data;
        end
    end

    // Clear on commit first so that a same-edge set for a new producer wins
    always_comb begin
        pending_d = pending_q;
        if (we_q) begin
            pending_d[addr_q] = 1'b0;
        end
        if (issue_accept) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_addr_rd      = addr_q;
    assign rf_data_rd      = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus hand sequences
// for scoreboard timing, the set-wins-over-clear case and reset mid-traffic.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        issue_valid, issue_rd_en;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        stall;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .issue_valid    (issue_valid),
        .issue_rd_en    (issue_rd_en),
        .issue_rd       (issue_rd),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .stall          (stall),
        .rf_write_enable(rf_write_enable),
        .rf_addr_rd     (rf_addr_rd),
        .rf_data_rd     (rf_data_rd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  vld;
        logic [14:0] addr;
        logic [95:0] data;
        logic        iv;
        logic        ien;
        logic [4:0]  ird;
        logic [4:0]  irs1;
        logic [4:0]  irs2;
        logic [2:0]  rdy;
        logic        stl;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [2:0] vld, input logic [14:0] addr,
                                input logic [95:0] data, input logic iv, input logic ien,
                                input logic [4:0] ird, input logic [4:0] irs1,
                                input logic [4:0] irs2, input logic [2:0] rdy,
                                input logic stl, input logic we, input logic [4:0] waddr,
                                input logic [31:0] wdata);
        vec_t v;
        v.vld = vld; v.addr = addr; v.data = data;
        v.iv = iv; v.ien = ien; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
        v.rdy = rdy; v.stl = stl; v.we = we; v.waddr = waddr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [2:0] vld, input logic [14:0] addr,
                           input logic [95:0] data);
        req_valid = vld;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic set_issue(input logic iv, input logic ien, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = iv;
        issue_rd_en = ien;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
    endtask

    localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] D123 = {32'hA3, 32'hA2, 32'hA1};

    initial begin
        reset_n = 1'b0;
        set_req(3'b000, '0, '0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Cycle-by-cycle table; registered expectations reflect the previous cycle's handshake
        vecs[0]  = mk(3'b001, 15'd5, 96'hDEADBEEF, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        vecs[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 5'd5, 32'hDEADBEEF);
        vecs[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        vecs[3]  = mk(3'b100, {5'd3, 10'd0}, {32'h33, 64'd0}, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
        vecs[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 5'd3, 32'h33);
        vecs[5]  = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        vecs[6]  = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b010, 0, 1, 5'd1, 32'hA1);
        vecs[7]  = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b100, 0, 1, 5'd2, 32'hA2);
        vecs[8]  = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b001, 0, 1, 5'd3, 32'hA3);
        vecs[9]  = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b010, 0, 1, 5'd1, 32'hA1);
        vecs[10] = mk(3'b111, A123, D123, 0, 0, 0, 0, 0, 3'b100, 0, 1, 5'd2, 32'hA2);
        vecs[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 5'd3, 32'hA3);
        vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        vecs[13] = mk(3'b000, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 0);
        vecs[14] = mk(3'b001, 15'd0, 96'h12345678, 1, 0, 5'd0, 5'd0, 5'd0, 3'b001, 0, 0, 0, 0);
        vecs[15] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        vecs[16] = mk(3'b000, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 0);

        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("reset we", 64'(rf_write_enable), 64'd0);
        chk("reset addr", 64'(rf_addr_rd), 64'd0);
        chk("reset data", 64'(rf_data_rd), 64'd0);
        set_issue(1'b1, 1'b1, 5'd31, 5'd5, 5'd9);
        #1;
        chk("reset stall", 64'(stall), 64'd0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        for (int i = 0; i < NVEC; i++) begin
            set_req(vecs[i].vld, vecs[i].addr, vecs[i].data);
            set_issue(vecs[i].iv, vecs[i].ien, vecs[i].ird, vecs[i].irs1, vecs[i].irs2);
            #1;
            chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].stl));
            chk($sformatf("v%0d we", i), 64'(rf_write_enable), 64'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d waddr", i), 64'(rf_addr_rd), 64'(vecs[i].waddr));
                chk($sformatf("v%0d wdata", i), 64'(rf_data_rd), 64'(vecs[i].wdata));
            end
            tick();
        end
        set_req(3'b000, '0, '0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // RAW on x7: stall until the cycle after the register file commits
        set_issue(1'b1, 1'b1, 5'd7, 5'd1, 5'd2);
        #1;
        chk("raw issue rd7", 64'(stall), 64'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        set_req(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h77, 32'd0});
        #1;
        chk("raw stall N", 64'(stall), 64'd1);
        chk("raw load grant", 64'(req_ready), 64'b010);
        tick();
        set_req(3'b000, '0, '0);
        #1;
        chk("raw stall N+1", 64'(stall), 64'd1);
        chk("raw we N+1", 64'(rf_write_enable), 64'd1);
        chk("raw addr N+1", 64'(rf_addr_rd), 64'd7);
        chk("raw data N+1", 64'(rf_data_rd), 64'h77);
        tick();
        chk("raw stall N+2", 64'(stall), 64'd0);
        chk("raw we N+2", 64'(rf_write_enable), 64'd0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Untracked write to x9 commits on the edge that accepts a new producer of x9
        set_req(3'b100, {5'd9, 10'd0}, {32'h99, 64'd0});
        #1;
        chk("sw grant", 64'(req_ready), 64'b100);
        tick();
        set_req(3'b000, '0, '0);
        set_issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        chk("sw we", 64'(rf_write_enable), 64'd1);
        chk("sw addr", 64'(rf_addr_rd), 64'd9);
        chk("sw issue rd9", 64'(stall), 64'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("sw raw x9", 64'(stall), 64'd1);
        set_issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        chk("sw waw x9", 64'(stall), 64'd1);
        set_issue(1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
        #1;
        chk("sw no issue", 64'(stall), 64'd0);
        tick();

        // Reset with traffic in flight and x4 pending
        set_issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
        #1;
        chk("rst issue rd4", 64'(stall), 64'd0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
        #1;
        chk("rst x4 pending", 64'(stall), 64'd1);
        reset_n = 1'b0;
        set_req(3'b111, {5'd12, 5'd11, 5'd10}, {32'hC2, 32'hC1, 32'hC0});
        #1;
        chk("rst ready low", 64'(req_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst we after", 64'(rf_write_enable), 64'd0);
        chk("rst x4 cleared", 64'(stall), 64'd0);
        set_issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("rst x9 cleared", 64'(stall), 64'd0);
        chk("rst ptr restart", 64'(req_ready), 64'b001);
        tick();
        set_req(3'b000, '0, '0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rst post we", 64'(rf_write_enable), 64'd1);
        chk("rst post addr", 64'(rf_addr_rd), 64'd10);
        chk("rst post data", 64'(rf_data_rd), 64'hC0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
